// File: rtl/dual_cmos_pattern_gen.sv
// dual_cmos_pattern_gen: synthetic frame-synchronous dual RGB565 camera source
// with the expected fused pixel, for bring-up of the dual-sensor fusion path.
module dual_cmos_pattern_gen #(
    parameter int H_ACT   = 640,
    parameter int H_BLANK = 160,
    parameter int V_ACT   = 480,
    parameter int V_BLANK = 20
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        enable,
    input  logic [1:0]  pat0_sel,
    input  logic [1:0]  pat1_sel,
    output logic        cmos_vsync,
    output logic        cmos_href,
    output logic [15:0] cmos0_data,
    output logic [15:0] cmos1_data,
    output logic [15:0] exp_fusion,
    output logic [15:0] frame_cnt,
    output logic        frame_done
);
    localparam logic [15:0] H_LAST  = 16'(H_ACT + H_BLANK - 1);
    localparam logic [15:0] H_END   = 16'(H_ACT);
    localparam logic [15:0] VB_LAST = 16'(V_BLANK - 1);
    localparam logic [15:0] VA_LAST = 16'(V_ACT - 1);
    localparam logic [15:0] BAR_W   = 16'(H_ACT / 8);
    localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                         16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    typedef enum logic [1:0] {IDLE, VSYNC, VBLANK, ACTIVE} state_t;

    state_t      state;
    logic [15:0] h_cnt, v_cnt;
    logic [1:0]  sel0, sel1;
    logic        line_end, vb_done, frame_end, pix;
    logic [2:0]  bar;
    logic [15:0] p0, p1, fuse;

    // x and y arrive pre-shifted by 2, so bit 2 is the 16-pixel checker bit
    function automatic logic [15:0] pattern(input logic [1:0] sel, input logic [2:0] b,
                                            input logic [5:0] x, input logic [5:0] y);
        return sel == 2'd0 ? BARS[b] :
               sel == 2'd1 ? {x[5:1], x, x[5:1]} :
               sel == 2'd2 ? {y[5:1], y, y[5:1]} : {16{x[2] ^ y[2]}};
    endfunction

    function automatic logic [15:0] fuse565(input logic [15:0] a, input logic [15:0] c);
        return {5'((6'(a[15:11]) + 6'(c[15:11])) >> 1),
                6'((7'(a[10:5]) + 7'(c[10:5])) >> 1),
                5'((6'(a[4:0]) + 6'(c[4:0])) >> 1)};
    endfunction

    always_comb begin
        line_end  = h_cnt == H_LAST;
        vb_done   = state == VBLANK && line_end && v_cnt == VB_LAST;
        frame_end = state == ACTIVE && line_end && v_cnt == VA_LAST;
        pix       = state == ACTIVE && h_cnt < H_END;
        bar       = 3'(h_cnt / BAR_W);
        p0        = pattern(sel0, bar, h_cnt[7:2], v_cnt[7:2]);
        p1        = pattern(sel1, bar, h_cnt[7:2], v_cnt[7:2]);
        fuse      = fuse565(p0, p1);
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            h_cnt      <= '0;
            v_cnt      <= '0;
            sel0       <= '0;
            sel1       <= '0;
            cmos_vsync <= 1'b0;
            cmos_href  <= 1'b0;
            cmos0_data <= '0;
            cmos1_data <= '0;
            exp_fusion <= '0;
            frame_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            cmos_vsync <= state == VSYNC;
            cmos_href  <= pix;
            cmos0_data <= pix ? p0 : '0;
            cmos1_data <= pix ? p1 : '0;
            exp_fusion <= pix ? fuse : '0;
            frame_done <= frame_end;
            frame_cnt  <= frame_cnt + 16'(frame_end);
            h_cnt      <= state == IDLE || line_end ? '0 : h_cnt + 16'd1;
            v_cnt      <= state == IDLE || (line_end && state == VSYNC) || vb_done || frame_end
                          ? '0 : v_cnt + 16'(line_end);
            // selects change only when a new frame begins
            if (state == IDLE || frame_end) begin
                state <= enable ? VSYNC : IDLE;
                if (enable) begin
                    sel0 <= pat0_sel;
                    sel1 <= pat1_sel;
                end
            end else if (state == VSYNC && line_end)
                state <= VBLANK;
            else if (vb_done)
                state <= ACTIVE;
        end
    end
endmodule
